// File: rtl/kb_move_decoder.sv
// PS/2 set-2 scan-code decoder for maze movement: drains the kb_code FIFO,
// tracks E0/F0 prefixes, keeps a held-direction mask and times auto-repeat.
module kb_move_decoder #(
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_W         = 24,
  parameter int ENABLE_WASD   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_code,
  input  logic       kb_buf_empty,
  output logic       rd_key_code,
  output logic [3:0] move_pulse,
  output logic [3:0] held,
  output logic       esc_pulse
);

  localparam logic [CNT_W-1:0] LP_DELAY  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] LP_PERIOD = CNT_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_last;
  logic             w_make, w_brk, w_ext;
  logic [3:0]       w_dir;
  logic             w_esc;
  logic             w_fresh, w_brk_last;

  // A byte is consumed on the edge where the pop strobe is high.
  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    w_ext       = 1'b0;
    if (rd_key_code) begin
      case (r_state)
        S_IDLE: begin
          if (key_code == 8'hE0)      w_state_nxt = S_EXT;
          else if (key_code == 8'hF0) w_state_nxt = S_BRK;
          else                        w_make = 1'b1;
        end
        S_EXT: begin
          if (key_code == 8'hF0)      w_state_nxt = S_EXT_BRK;
          else if (key_code != 8'hE0) begin
            w_make      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          if (key_code != 8'hF0) begin
            w_brk       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (key_code != 8'hE0 && key_code != 8'hF0) begin
            w_brk       = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Direction bits are {right,left,down,up}; WASD shares bits with the arrows.
  always_comb begin
    w_dir = 4'b0000;
    w_esc = 1'b0;
    if (w_ext) begin
      case (key_code)
        8'h75:   w_dir = 4'b0001;
        8'h72:   w_dir = 4'b0010;
        8'h6B:   w_dir = 4'b0100;
        8'h74:   w_dir = 4'b1000;
        default: w_dir = 4'b0000;
      endcase
    end else begin
      if (ENABLE_WASD != 0) begin
        case (key_code)
          8'h1D:   w_dir = 4'b0001;
          8'h1B:   w_dir = 4'b0010;
          8'h1C:   w_dir = 4'b0100;
          8'h23:   w_dir = 4'b1000;
          default: w_dir = 4'b0000;
        endcase
      end
      w_esc = (key_code == 8'h76);
    end
  end

  assign w_fresh    = w_make && (w_dir != 4'b0000) && ((held & w_dir) == 4'b0000);
  assign w_brk_last = w_brk && (w_dir != 4'b0000) && (w_dir == r_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_key_code <= 1'b0;
      move_pulse  <= 4'b0000;
      held        <= 4'b0000;
      esc_pulse   <= 1'b0;
      r_cnt       <= '0;
      r_last      <= 4'b0000;
    end else begin
      rd_key_code <= !kb_buf_empty && !rd_key_code;
      move_pulse  <= 4'b0000;
      esc_pulse   <= w_make && w_esc;
      if (w_fresh) begin
        // A fresh press takes over the repeat timer, beating any expiry.
        held       <= held | w_dir;
        move_pulse <= w_dir;
        r_last     <= w_dir;
        r_cnt      <= LP_DELAY;
      end else if (w_brk_last) begin
        held   <= held & ~w_dir;
        r_last <= 4'b0000;
        r_cnt  <= '0;
      end else begin
        if (w_brk) held <= held & ~w_dir;
        if (r_last != 4'b0000 && r_cnt != '0) begin
          if (r_cnt == CNT_W'(1)) begin
            move_pulse <= r_last;
            r_cnt      <= LP_PERIOD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_kb_move_decoder.sv
// Directed bench for kb_move_decoder: a FIFO-driving task feeds bytes and a
// scoreboard of expected pulse cycles is checked by a negedge monitor.
module tb_kb_move_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] key_code;
  logic       kb_buf_empty;
  logic       rd_key_code;
  logic [3:0] move_pulse;
  logic [3:0] held;
  logic       esc_pulse;

  kb_move_decoder #(
    .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .CNT_W(8), .ENABLE_WASD(1)
  ) dut (
    .clk(clk), .reset(reset), .key_code(key_code), .kb_buf_empty(kb_buf_empty),
    .rd_key_code(rd_key_code), .move_pulse(move_pulse), .held(held),
    .esc_pulse(esc_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [3:0] mv; logic esc;} ev_t;
  ev_t sb[$];

  int cyc = 0;
  int rd_cnt = 0;
  int n_chk = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input int c, input logic [3:0] mv, input logic esc);
    ev_t e;
    e.cyc = c; e.mv = mv; e.esc = esc;
    sb.push_back(e);
  endtask

  // Every pulse observed must match the next scoreboard entry in cycle and value.
  always @(negedge clk) begin
    if (rd_key_code) rd_cnt++;
    if (move_pulse != 4'b0000 || esc_pulse) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {27'd0, esc_pulse, move_pulse}, 32'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_value", {27'd0, esc_pulse, move_pulse}, {27'd0, e.esc, e.mv});
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Present one byte at the FIFO head; returns the cycle count of its consuming edge.
  task automatic send(input logic [7:0] b, output int c);
    @(negedge clk);
    key_code = b;
    kb_buf_empty = 1'b0;
    for (int i = 0; i < 8 && !rd_key_code; i++) @(negedge clk);
    check("rd_rise", {31'd0, rd_key_code}, 32'd1);
    @(posedge clk);
    #1;
    c = cyc;
    kb_buf_empty = 1'b1;
    check("rd_one_cycle", {31'd0, rd_key_code}, 32'd0);
  endtask

  task automatic drained(input string tag);
    check(tag, sb.size(), 0);
  endtask

  initial begin
    int c, c1, c2, d, r0;
    reset = 1'b1;
    key_code = 8'h00;
    kb_buf_empty = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {22'd0, rd_key_code, move_pulse, held, esc_pulse}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single up press, repeat timing, then release.
    r0 = rd_cnt;
    send(8'hE0, d);
    send(8'h75, c);
    push(c, 4'b0001, 1'b0); push(c + 20, 4'b0001, 1'b0);
    push(c + 28, 4'b0001, 1'b0); push(c + 36, 4'b0001, 1'b0);
    check("rd_count_two", rd_cnt - r0, 2);
    check("held_up", {28'd0, held}, 32'h1);
    wait_cyc(c + 21);
    send(8'hE0, d); send(8'hF0, d);
    wait_cyc(c + 37);
    send(8'h75, d);
    check("held_up_released", {28'd0, held}, 32'h0);
    wait_cyc(c + 60);
    drained("drain_up");

    // Left then right: only the latest direction repeats.
    send(8'hE0, d); send(8'h6B, c1);
    push(c1, 4'b0100, 1'b0);
    send(8'hE0, d); send(8'h74, c2);
    push(c2, 4'b1000, 1'b0); push(c2 + 20, 4'b1000, 1'b0);
    push(c2 + 28, 4'b1000, 1'b0); push(c2 + 36, 4'b1000, 1'b0);
    check("held_left_right", {28'd0, held}, 32'hC);
    send(8'hE0, d); send(8'hF0, d); send(8'h6B, d);
    check("held_right_only", {28'd0, held}, 32'h8);
    wait_cyc(c2 + 29);
    send(8'hE0, d); send(8'hF0, d);
    wait_cyc(c2 + 37);
    send(8'h74, d);
    check("held_right_released", {28'd0, held}, 32'h0);
    wait_cyc(c2 + 60);
    drained("drain_left_right");

    // Typematic repeats of a held key are ignored.
    send(8'hE0, d); send(8'h75, c);
    push(c, 4'b0001, 1'b0); push(c + 20, 4'b0001, 1'b0);
    push(c + 28, 4'b0001, 1'b0); push(c + 36, 4'b0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      send(8'hE0, d); send(8'h75, d);
    end
    check("held_typematic", {28'd0, held}, 32'h1);
    wait_cyc(c + 29);
    send(8'hE0, d); send(8'hF0, d);
    wait_cyc(c + 37);
    send(8'h75, d);
    wait_cyc(c + 60);
    drained("drain_typematic");

    // WASD alias.
    send(8'h1D, c);
    push(c, 4'b0001, 1'b0);
    check("held_wasd", {28'd0, held}, 32'h1);
    send(8'hF0, d); send(8'h1D, d);
    check("held_wasd_released", {28'd0, held}, 32'h0);
    repeat (30) @(negedge clk);
    drained("drain_wasd");

    // Escape, unknown byte, then left via A.
    send(8'h76, c);
    push(c, 4'b0000, 1'b1);
    check("held_after_esc", {28'd0, held}, 32'h0);
    send(8'h5A, d);
    send(8'h1C, c);
    push(c, 4'b0100, 1'b0);
    check("held_a", {28'd0, held}, 32'h4);
    send(8'hF0, d); send(8'h1C, d);
    check("held_a_released", {28'd0, held}, 32'h0);
    repeat (30) @(negedge clk);
    drained("drain_esc");

    // Reset in the middle of an E0 prefix while a key is held.
    send(8'hE0, d); send(8'h75, c);
    push(c, 4'b0001, 1'b0);
    check("held_before_reset", {28'd0, held}, 32'h1);
    send(8'hE0, d);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("outputs_in_reset", {22'd0, rd_key_code, move_pulse, held, esc_pulse}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send(8'h75, d);
    repeat (30) @(negedge clk);
    check("held_after_reset", {28'd0, held}, 32'h0);
    drained("drain_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/kb_move_decoder.md
Name: kb_move_decoder

Overview:
- Consumes PS/2 set-2 scan codes from the keyboard code FIFO (kb_code) and converts them into maze-game movement commands.
- Drains the FIFO through the rd_key_code/kb_buf_empty handshake and tracks E0 (extended) and F0 (break) prefixes.
- Maintains a held-key mask and emits one-cycle move pulses, with internally timed auto-repeat; keyboard typematic repeats are ignored.
- Sits between kb_code and the maze player-position logic.

Parameters:
- REPEAT_DELAY, 12500000: cycles from a fresh press to the first repeat pulse (250 ms at 50 MHz).
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat pulses (100 ms at 50 MHz).
- CNT_W, 24: width of the repeat counter; must hold max(REPEAT_DELAY, REPEAT_PERIOD).
- ENABLE_WASD, 1: when 1, W/A/S/D (1D/1C/1B/23) alias the arrow keys.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- key_code, input, 8: head of the kb_code FIFO (show-ahead); valid when kb_buf_empty=0.
- kb_buf_empty, input, 1: FIFO empty flag.
- rd_key_code, output, 1: FIFO pop strobe (registered).
- move_pulse, output, 4: one-cycle direction pulses, one-hot {right,left,down,up}.
- held, output, 4: currently held directions, same bit order as move_pulse.
- esc_pulse, output, 1: one-cycle pulse on Escape (76) make code.

Behaviour:
- Reset (async, active-high): rd_key_code=0, move_pulse=0, held=0, esc_pulse=0. Prefix FSM goes to IDLE; repeat counter=0; last_dir=0.
- Handshake:
  - rd_key_code is set for exactly one cycle on the edge where kb_buf_empty=0 and rd_key_code=0.
  - This gives at most one pop every 2 cycles, so there is no double-pop while the empty flag updates.
  - The byte is consumed on the edge where rd_key_code=1, sampling key_code that cycle.
- Latency: the pulse caused by a byte is visible in the cycle after the consuming edge, i.e. 2 cycles after kb_buf_empty falls.
- Prefix FSM states: IDLE, EXT (seen E0), BRK (seen F0), EXT_BRK (seen E0 F0).
  - IDLE: E0 -> EXT; F0 -> BRK; other byte -> make(normal), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte -> make(extended), go IDLE.
  - BRK: F0 -> stay BRK; other byte -> break(normal), go IDLE.
  - EXT_BRK: other byte -> break(extended), go IDLE. (E0/F0 never arrive in this state; if they do, stay.)
- Key map:
  - Extended: 75=up, 72=down, 6B=left, 74=right.
  - Normal, only if ENABLE_WASD: 1D=up, 1B=down, 1C=left, 23=down-right pairing is not used; 23=right.
  - Normal 76 = Escape.
  - All other codes are ignored and the FSM still returns to IDLE.
- Make of direction d:
  - If held[d]=0: set held[d], pulse move_pulse[d], set last_dir=d, load counter=REPEAT_DELAY.
  - If held[d]=1 (typematic repeat): no action.
- Break of direction d:
  - Clear held[d].
  - If d==last_dir: clear counter and last_dir, so repeat stops.
  - Break of a key not held: no effect.
- Repeat:
  - While last_dir!=0 and counter!=0, the counter decrements each cycle.
  - On the cycle the counter reaches 1: pulse move_pulse[last_dir] and reload REPEAT_PERIOD.
  - Only last_dir repeats; other held keys never repeat.
- Simultaneous events: if a byte-driven pulse and a repeat expiry coincide, the byte event wins. Its reload supersedes and no repeat pulse is issued that cycle. move_pulse is always one-hot or zero.
- Escape make: esc_pulse for one cycle; held and repeat are unaffected. Escape break is ignored.
- An arrow key and its WASD alias share the held bit; break of either clears it.
- Reset asserted mid-sequence (e.g. after E0) discards the partial prefix.

Test Plan:
- Feed E0 75 -> rd_key_code pulses twice; move_pulse=0001 for one cycle; held=0001; no further pulse within 4 cycles (with REPEAT_DELAY=20, REPEAT_PERIOD=8).
- Hold up (E0 75) with REPEAT_DELAY=20, REPEAT_PERIOD=8 -> repeat pulses at +20, +28, +36 cycles after the first pulse. Then feed E0 F0 75 -> held=0000 and no more pulses.
- E0 6B, then E0 74 (both held) -> pulses 0100 then 1000; repeats only 1000. E0 F0 6B -> held=1000 and 1000 repeats continue. E0 F0 74 -> repeats stop.
- Typematic: E0 75 sent 5 times -> exactly one immediate pulse; repeat timing unaffected. ENABLE_WASD=1: 1D -> move_pulse=0001; F0 1D -> held=0.
- 76 -> esc_pulse for one cycle. Unknown byte 5A -> no outputs, FSM back in IDLE (next 1C gives 0100).
- Feed E0, assert reset for 1 cycle mid-stream, then feed 75 -> outputs zero during reset; 75 is treated as normal and ignored; held=0.
